// File: rtl/fir_da_sequencer.sv
// Control sequencer for the distributed-arithmetic FIR: one handshaked sample in,
// delay-line shift, shift-register load, DATA_W MSB-first accumulate cycles, result handshake out.
module fir_da_sequencer #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 64,
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             delay_shift,
    output logic             sr_load,
    output logic             sr_shift,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             acc_sub,
    output logic [IDX_W-1:0] bit_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             primed,
    output logic             busy
);

    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAPS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_IN = 3'd1,
        LOAD     = 3'd2,
        BITS     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;
    logic [IDX_W-1:0] bit_idx_d;
    logic             accept;

    // in_ready is gated by resetn so nothing is offered while reset is held
    assign in_ready = resetn & run & (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = SHIFT_IN;
            SHIFT_IN: state_d = LOAD;
            LOAD:     state_d = BITS;
            BITS:     if (bit_idx == '0) state_d = DONE;
            DONE:     if (out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        if (accept && (fill_q != CNT_FULL))
            fill_d = fill_q + 1'b1;
    end

    // bit_idx presents the bit the shift registers show in the coming cycle
    always_comb begin
        bit_idx_d = '0;
        case (state_d)
            LOAD:    bit_idx_d = IDX_MSB;
            BITS:    bit_idx_d = (state_q == BITS) ? bit_idx - 1'b1 : bit_idx;
            default: bit_idx_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            primed      <= 1'b0;
            delay_shift <= 1'b0;
            sr_load     <= 1'b0;
            acc_clr     <= 1'b0;
            sr_shift    <= 1'b0;
            acc_en      <= 1'b0;
            acc_sub     <= 1'b0;
            out_valid   <= 1'b0;
            bit_idx     <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            primed      <= (fill_d == CNT_FULL);
            delay_shift <= (state_d == SHIFT_IN);
            sr_load     <= (state_d == LOAD);
            acc_clr     <= (state_d == LOAD);
            sr_shift    <= (state_d == BITS);
            acc_en      <= (state_d == BITS);
            // sign bit of the two's-complement sample is weighted negatively
            acc_sub     <= (state_d == BITS) && (bit_idx_d == IDX_MSB);
            out_valid   <= (state_d == DONE);
            bit_idx     <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_fir_da_sequencer.sv
// Bench for fir_da_sequencer: timeline reference model (cycles since acceptance)
// compared against every output each cycle under directed and random stimulus.
module tb_fir_da_sequencer;

    localparam int DATA_W = 16;
    localparam int TAPS   = 64;
    localparam int IDX_W  = $clog2(DATA_W);

    logic             clk = 1'b0;
    logic             resetn;
    logic             run;
    logic             in_valid;
    logic             in_ready;
    logic             delay_shift;
    logic             sr_load;
    logic             sr_shift;
    logic             acc_clr;
    logic             acc_en;
    logic             acc_sub;
    logic [IDX_W-1:0] bit_idx;
    logic             out_valid;
    logic             out_ready;
    logic             primed;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position in the per-sample timeline and accepted-sample count
    bit m_active;
    int m_t;
    int m_cnt;

    fir_da_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn), .run(run), .in_valid(in_valid), .in_ready(in_ready),
        .delay_shift(delay_shift), .sr_load(sr_load), .sr_shift(sr_shift),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_sub(acc_sub), .bit_idx(bit_idx),
        .out_valid(out_valid), .out_ready(out_ready), .primed(primed), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_cnt    = 0;
    endtask

    task automatic model_edge();
        if (!resetn) return;
        if (!m_active) begin
            if (run && in_valid) begin
                m_active = 1'b1;
                m_t      = 1;
                if (m_cnt < TAPS) m_cnt++;
            end
        end else if (m_t < DATA_W + 3) begin
            m_t++;
        end else if (out_ready) begin
            m_active = 1'b0;
            m_t      = 0;
        end
    endtask

    task automatic compare();
        bit in_bits;
        in_bits = m_active && (m_t >= 3) && (m_t <= DATA_W + 2);
        check("in_ready",    in_ready,    (!m_active && run && resetn) ? 1 : 0);
        check("busy",        busy,        m_active ? 1 : 0);
        check("delay_shift", delay_shift, (m_active && m_t == 1) ? 1 : 0);
        check("sr_load",     sr_load,     (m_active && m_t == 2) ? 1 : 0);
        check("acc_clr",     acc_clr,     (m_active && m_t == 2) ? 1 : 0);
        check("sr_shift",    sr_shift,    in_bits ? 1 : 0);
        check("acc_en",      acc_en,      in_bits ? 1 : 0);
        check("acc_sub",     acc_sub,     (m_active && m_t == 3) ? 1 : 0);
        check("out_valid",   out_valid,   (m_active && m_t == DATA_W + 3) ? 1 : 0);
        check("primed",      primed,      (m_cnt == TAPS) ? 1 : 0);
        if (in_bits)
            check("bit_idx", bit_idx, DATA_W + 2 - m_t);
        else if (!resetn)
            check("bit_idx_rst", bit_idx, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        bit found;
        resetn = 1'b0; run = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();

        // Reset state, with upstream already requesting
        @(negedge clk);
        compare();
        run = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1 compare();
        @(negedge clk);
        compare();
        resetn = 1'b1;
        #1 compare();

        // Back-to-back samples, enough to fill the delay line and saturate the count
        for (int i = 0; i < 70 * (DATA_W + 4); i++) cyc();

        // Downstream stalls for 10 cycles once a result is offered
        found = 1'b0;
        for (int i = 0; i < 4 * DATA_W && !found; i++) begin
            out_ready = 1'b0;
            cyc();
            found = m_active && (m_t == DATA_W + 3);
        end
        if (!found) check("stall_wait_timeout", 0, 1);
        for (int i = 0; i < 10; i++) cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();

        // run low: input stays pending, nothing accepted
        found = 1'b0;
        for (int i = 0; i < 4 * DATA_W && !found; i++) begin
            cyc();
            found = !m_active;
        end
        if (!found) check("idle_wait_timeout", 0, 1);
        run = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) cyc();
        run = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // Randomised handshakes, including run toggling mid-sample
        for (int i = 0; i < 1500; i++) begin
            run       = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        // Asynchronous reset in the middle of the bit-serial phase at bit 7
        found = 1'b0;
        run = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8 * DATA_W && !found; i++) begin
            cyc();
            found = m_active && (m_t == DATA_W + 2 - 7);
        end
        if (!found) check("bit7_wait_timeout", 0, 1);
        check("bit_idx_before_reset", bit_idx, 7);
        #2 resetn = 1'b0;
        #1 model_reset();
        compare();
        in_valid = 1'b0;
        @(negedge clk);
        compare();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        in_valid = 1'b1;
        for (int i = 0; i < 3 * (DATA_W + 4); i++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
